// File: rtl/pipe_cla_adder_cla_nbit.sv
// ============================================================================
// cla_nbit : combinational N-bit carry-lookahead adder, no state
// Rev 1.0
// ============================================================================
`default_nettype none

module cla_nbit #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [N-1:0] w_g;
    logic [N-1:0] w_p;
    logic [N:0]   w_c;
    logic         w_acc;
    logic         w_prop;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry is a flat sum-of-products of generates and the carry-in,
    // never the previous carry, so the depth does not grow with bit position.
    always_comb begin
        w_c    = '0;
        w_acc  = 1'b0;
        w_prop = 1'b0;
        w_c[0] = cin;
        for (int i = 0; i < N; i++) begin
            w_acc  = w_g[i];
            w_prop = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_acc  = w_acc | (w_prop & w_g[j]);
                w_prop = w_prop & w_p[j];
            end
            w_c[i+1] = w_acc | (w_prop & cin);
        end
    end

    assign sum   = w_p ^ w_c[N-1:0];
    assign cout  = w_c[N];
    assign c_msb = w_c[N-1];

endmodule

`default_nettype wire

// File: rtl/pipe_cla_adder.sv
// ============================================================================
// pipe_cla_adder : pipelined block carry-lookahead add/subtract, deskewed output
// Rev 1.0
// ============================================================================
`default_nettype none

module pipe_cla_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / BLOCK;

    if (((WIDTH % BLOCK) != 0) || (BLOCK < 2) || (WIDTH < BLOCK)) begin : g_bad_params
        $error("pipe_cla_adder: WIDTH must be a multiple of BLOCK, BLOCK >= 2, WIDTH >= BLOCK");
    end

    // Rank k feeds block k; rank STAGES is the output register.
    logic [STAGES-1:0][WIDTH-1:0] r_a;
    logic [STAGES-1:0][WIDTH-1:0] r_b;
    logic [STAGES:0][WIDTH-1:0]   r_s;
    logic [STAGES:0]              r_c;
    logic [STAGES:0]              r_v;
    logic                         r_ovf;

    logic [STAGES-1:0][BLOCK-1:0] w_blk_sum;
    logic [STAGES-1:0]            w_blk_cout;
    logic [STAGES-1:0]            w_blk_cmsb;
    logic [STAGES-1:0][WIDTH-1:0] w_s_next;
    logic                         w_adv;
    logic                         w_unused;

    assign w_adv = out_ready | ~r_v[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_nbit #(
            .N (BLOCK)
        ) u_cla (
            .a     (r_a[k][BLOCK-1:0]),
            .b     (r_b[k][BLOCK-1:0]),
            .cin   (r_c[k]),
            .sum   (w_blk_sum[k]),
            .cout  (w_blk_cout[k]),
            .c_msb (w_blk_cmsb[k])
        );
    end

    always_comb begin
        w_s_next = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_s_next[k]                  = r_s[k];
            w_s_next[k][k*BLOCK +: BLOCK] = w_blk_sum[k];
        end
    end

    // Operands shift down one block per stage so each block always reads
    // the low BLOCK bits; subtraction folds into ~b with a forced carry-in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_s   <= '0;
            r_c   <= '0;
            r_v   <= '0;
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_v[0] <= in_valid;
            r_a[0] <= a;
            r_b[0] <= sub ? ~b : b;
            r_c[0] <= sub | cin;
            r_s[0] <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_v[k+1] <= r_v[k];
                r_c[k+1] <= w_blk_cout[k];
                r_s[k+1] <= w_s_next[k];
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                r_a[k+1] <= r_a[k] >> BLOCK;
                r_b[k+1] <= r_b[k] >> BLOCK;
            end
            r_ovf <= w_blk_cout[STAGES-1] ^ w_blk_cmsb[STAGES-1];
        end
    end

    assign w_unused = ^{r_a[STAGES-1], r_b[STAGES-1], w_blk_cmsb};

    assign in_ready  = w_adv;
    assign out_valid = r_v[STAGES];
    assign sum       = r_s[STAGES];
    assign cout      = r_c[STAGES];
    assign ovf       = r_ovf;

endmodule

`default_nettype wire
